// File: rtl/ad_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding and default width.
package ad_pkg;

    localparam int DEFAULT_N = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PREP = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_t;

endpackage

// File: rtl/ad_cond_negate.sv
// Combinational conditional two's-complement negation: Out = Flip ? -In : In.
module ad_cond_negate #(
    parameter int N = 8
) (
    input  logic [N-1:0] In,
    input  logic         Flip,
    output logic [N-1:0] Out
);

    assign Out = Flip ? (~In + N'(1)) : In;

endmodule

// File: rtl/ad_seq_signed_divider.sv
// Iterative restoring divider, one quotient bit per cycle, signed or unsigned per operation.
// Handshake: Start is accepted only in IDLE; Busy covers the op, Done pulses one cycle with results.
module ad_seq_signed_divider
    import ad_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         Start,
    input  logic         Signed,
    input  logic [N-1:0] Dividend,
    input  logic [N-1:0] Divisor,
    output logic         Busy,
    output logic         Done,
    output logic [N-1:0] Quotient,
    output logic [N-1:0] Remainder,
    output logic         DivZero,
    output logic         Overflow,
    output logic [1:0]   dbg_state
);

    localparam int               CNT_W    = $clog2(N + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
    localparam logic [N-1:0]     SMIN     = {1'b1, {(N-1){1'b0}}};

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [N-1:0]     dividend_l;
    logic [N-1:0]     divisor_l;
    logic             signed_l;
    logic             dvd_neg;
    logic             dvs_neg;
    logic [N-1:0]     dvs_mag;
    logic [N-1:0]     quo;
    logic [N-1:0]     rem;

    logic             in_prep;
    logic [N-1:0]     neg_a_in;
    logic [N-1:0]     neg_b_in;
    logic             neg_a_flip;
    logic             neg_b_flip;
    logic [N-1:0]     neg_a_out;
    logic [N-1:0]     neg_b_out;
    logic [N:0]       rem_sh;
    logic [N-1:0]     trial;
    logic             fits;
    logic             div_zero;
    logic             min_over;

    // Two negators shared between PREP (operand magnitudes) and FIX (result sign correction).
    always_comb begin
        in_prep    = (state == ST_PREP);
        neg_a_in   = in_prep ? dividend_l : quo;
        neg_a_flip = signed_l & (in_prep ? dvd_neg : (dvd_neg ^ dvs_neg));
        neg_b_in   = in_prep ? divisor_l : rem;
        neg_b_flip = signed_l & (in_prep ? dvs_neg : dvd_neg);
    end

    ad_cond_negate #(.N(N)) u_neg_a (
        .In   (neg_a_in),
        .Flip (neg_a_flip),
        .Out  (neg_a_out)
    );

    ad_cond_negate #(.N(N)) u_neg_b (
        .In   (neg_b_in),
        .Flip (neg_b_flip),
        .Out  (neg_b_out)
    );

    // Partial remainder stays below |Divisor|, so N bits suffice; the shifted value needs N+1.
    always_comb begin
        rem_sh   = {rem, quo[N-1]};
        fits     = (rem_sh >= {1'b0, dvs_mag});
        trial    = rem_sh[N-1:0] - dvs_mag;
        div_zero = (divisor_l == '0);
        min_over = signed_l && (dividend_l == SMIN) && (divisor_l == '1);
    end

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            dividend_l <= '0;
            divisor_l  <= '0;
            signed_l   <= 1'b0;
            dvd_neg    <= 1'b0;
            dvs_neg    <= 1'b0;
            dvs_mag    <= '0;
            quo        <= '0;
            rem        <= '0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            Quotient   <= '0;
            Remainder  <= '0;
            DivZero    <= 1'b0;
            Overflow   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        dividend_l <= Dividend;
                        divisor_l  <= Divisor;
                        signed_l   <= Signed;
                        dvd_neg    <= Dividend[N-1];
                        dvs_neg    <= Divisor[N-1];
                        DivZero    <= 1'b0;
                        Overflow   <= 1'b0;
                        Busy       <= 1'b1;
                        state      <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    quo     <= neg_a_out;
                    dvs_mag <= neg_b_out;
                    rem     <= '0;
                    cnt     <= CNT_LAST;
                    state   <= ST_DIV;
                end
                ST_DIV: begin
                    quo <= {quo[N-2:0], fits};
                    rem <= fits ? trial : rem_sh[N-1:0];
                    if (cnt == '0) begin
                        state <= ST_FIX;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_FIX: begin
                    if (div_zero) begin
                        Quotient  <= '1;
                        Remainder <= dividend_l;
                        DivZero   <= 1'b1;
                    end else if (min_over) begin
                        Quotient  <= SMIN;
                        Remainder <= '0;
                        Overflow  <= 1'b1;
                    end else begin
                        Quotient  <= neg_a_out;
                        Remainder <= neg_b_out;
                    end
                    Done  <= 1'b1;
                    Busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ad_seq_signed_divider.sv
// Directed bench for the sequential divider: behavioural model in an expected queue plus literal checks.
module tb_ad_seq_signed_divider;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         Start = 1'b0;
    logic         Signed = 1'b0;
    logic [N-1:0] Dividend = '0;
    logic [N-1:0] Divisor = '0;
    logic         Busy;
    logic         Done;
    logic [N-1:0] Quotient;
    logic [N-1:0] Remainder;
    logic         DivZero;
    logic         Overflow;
    logic [1:0]   dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int acc_cyc = 0;

    logic [2*N+1:0] exp_q[$];
    logic [2*N+1:0] exp_e;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    ad_seq_signed_divider #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .Start     (Start),
        .Signed    (Signed),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Busy      (Busy),
        .Done      (Done),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .DivZero   (DivZero),
        .Overflow  (Overflow),
        .dbg_state (dbg_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Result packed as {quotient, remainder, divzero, overflow}, from plain integer arithmetic.
    function automatic logic [2*N+1:0] model(input bit s, input logic [N-1:0] a, input logic [N-1:0] b);
        int sa;
        int sb;
        int q;
        int r;
        if (b == '0) return {8'hFF, a, 1'b1, 1'b0};
        if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            if (sa == -128 && sb == -1) return {8'h80, 8'h00, 1'b0, 1'b1};
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = int'(a) / int'(b);
            r = int'(a) % int'(b);
        end
        return {q[7:0], r[7:0], 1'b0, 1'b0};
    endfunction

    // Every Done cycle is compared against the oldest queued model result.
    always @(negedge clk) begin
        if (!reset && Done) begin
            check("busy_low_at_done", Busy, 0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_done: got Done=1 required no Done (cycle %0d)", cyc);
            end else begin
                exp_e = exp_q.pop_front();
                check("model_quotient", Quotient, exp_e[2*N+1:N+2]);
                check("model_remainder", Remainder, exp_e[N+1:2]);
                check("model_divzero", DivZero, exp_e[1]);
                check("model_overflow", Overflow, exp_e[0]);
            end
        end
    end

    // Drives one Start cycle from the current point; returns #1 after the accepting edge.
    task automatic launch(input bit s, input logic [N-1:0] a, input logic [N-1:0] b);
        Signed   = s;
        Dividend = a;
        Divisor  = b;
        Start    = 1'b1;
        exp_q.push_back(model(s, a, b));
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        Start    = 1'b0;
        Dividend = ~a;
        Divisor  = ~b;
        Signed   = ~s;
        check("busy_after_start", Busy, 1);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (Done !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (Done !== 1'b1) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: got no Done within 40 cycles, required Done", name);
        end else begin
            check({name, "_latency"}, cyc - acc_cyc, N + 2);
        end
    endtask

    task automatic run(input string name, input bit s, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] eq, input logic [N-1:0] er, input bit edz, input bit eov);
        @(negedge clk);
        launch(s, a, b);
        wait_done(name);
        check({name, "_q"}, Quotient, eq);
        check({name, "_r"}, Remainder, er);
        check({name, "_dz"}, DivZero, edz);
        check({name, "_ov"}, Overflow, eov);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", Busy, 0);
        check("reset_done", Done, 0);
        check("reset_q", Quotient, 0);
        check("reset_r", Remainder, 0);
        check("reset_dz", DivZero, 0);
        check("reset_ov", Overflow, 0);
        check("reset_state", dbg_state, 0);
        @(negedge clk);
        reset = 1'b0;

        run("u100_7",     0, 8'd100, 8'd7,   8'h0E, 8'h02, 0, 0);
        run("s_m100_7",   1, 8'h9C,  8'h07,  8'hF2, 8'hFE, 0, 0);
        run("s_100_m7",   1, 8'd100, 8'hF9,  8'hF2, 8'h02, 0, 0);
        run("s_m100_m7",  1, 8'h9C,  8'hF9,  8'h0E, 8'hFE, 0, 0);
        run("s_min_m1",   1, 8'h80,  8'hFF,  8'h80, 8'h00, 0, 1);
        run("u_80_ff",    0, 8'h80,  8'hFF,  8'h00, 8'h80, 0, 0);
        run("u_5_0",      0, 8'h05,  8'h00,  8'hFF, 8'h05, 1, 0);
        run("s_5_0",      1, 8'h05,  8'h00,  8'hFF, 8'h05, 1, 0);
        run("s_min_7",    1, 8'h80,  8'h07,  8'hEE, 8'hFE, 0, 0);
        run("u_ff_1",     0, 8'hFF,  8'h01,  8'hFF, 8'h00, 0, 0);
        run("s_7f_min",   1, 8'h7F,  8'h80,  8'h00, 8'h7F, 0, 0);
        run("u_3_10",     0, 8'd3,   8'd10,  8'h00, 8'h03, 0, 0);

        // Start pulsed mid-operation must be ignored.
        @(negedge clk);
        launch(0, 8'd200, 8'd3);
        repeat (3) @(posedge clk);
        @(negedge clk);
        Start    = 1'b1;
        Signed   = 1'b1;
        Dividend = 8'd9;
        Divisor  = 8'd3;
        @(negedge clk);
        Start = 1'b0;
        wait_done("ignored_start");
        check("ignored_start_q", Quotient, 8'h42);
        check("ignored_start_r", Remainder, 8'h02);

        // Start in the Done cycle is accepted.
        launch(1, 8'h9C, 8'h07);
        wait_done("back_to_back");
        check("back_to_back_q", Quotient, 8'hF2);
        check("back_to_back_r", Remainder, 8'hFE);

        // Reset in the middle of the iteration aborts without Done.
        @(negedge clk);
        launch(0, 8'd100, 8'd7);
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        check("midreset_busy", Busy, 0);
        check("midreset_done", Done, 0);
        check("midreset_q", Quotient, 0);
        check("midreset_r", Remainder, 0);
        check("midreset_dz", DivZero, 0);
        check("midreset_ov", Overflow, 0);
        check("midreset_state", dbg_state, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("midreset_no_done", Done, 0);
        check("midreset_idle_busy", Busy, 0);

        run("after_reset", 0, 8'd100, 8'd7, 8'h0E, 8'h02, 0, 0);

        repeat (3) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
